// File: rtl/arc_mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The optional divide datapath is enabled with ARC_MDU_DIV_EN.
package arc_mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_ITER = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the sequencer on the {upper, lower} accumulator: shift-add multiply,
// or restoring shift-subtract divide when ARC_MDU_DIV_EN is defined.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH:0]   i_mag_b,
`ifdef ARC_MDU_DIV_EN
  input  logic             i_div,
`endif
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_mul;

  // Upper part never exceeds WIDTH+1 bits: it is < 2^WIDTH after each shift.
  assign w_add = i_acc[0] ? i_mag_b : '0;
  assign w_sum = i_acc[2*WIDTH:WIDTH] + w_add;
  assign w_mul = {1'b0, w_sum, i_acc[WIDTH-1:1]};

`ifdef ARC_MDU_DIV_EN
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_q;
  logic [WIDTH:0]   w_rem_new;
  logic [2*WIDTH:0] w_div;

  // Upper part holds the partial remainder, lower part the dividend shifting into quotient.
  assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = {1'b0, w_rem_sh} - {1'b0, i_mag_b};
  assign w_q       = ~w_diff[WIDTH+1];
  assign w_rem_new = w_q ? w_diff[WIDTH:0] : w_rem_sh;
  assign w_div     = {w_rem_new, i_acc[WIDTH-2:0], w_q};

  assign o_acc = i_div ? w_div : w_mul;
`else
  assign o_acc = w_mul;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and pipeline stall.
// Divide support is compiled only when ARC_MDU_DIV_EN is defined.
module mdu_ctrl
  import arc_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_con_Start,
  input  logic [1:0]       i_con_MduOp,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_con_RdHiLo,
  input  logic             i_con_WrHi,
  input  logic             i_con_WrLo,
  output logic [WIDTH-1:0] o_data_Hi,
  output logic [WIDTH-1:0] o_data_Lo,
  output logic             o_con_Busy,
  output logic             o_con_Stall,
  output logic             o_con_Done
);

  mdu_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH:0]   r_mag_b;
  logic             r_sa, r_sb;
  logic [WIDTH-1:0] r_hi, r_lo;

  mdu_op_t          w_op;
  logic             w_signed, w_op_ok, w_accept, w_busy;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [2*WIDTH:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  assign w_op     = mdu_op_t'(i_con_MduOp);
  assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
`ifdef ARC_MDU_DIV_EN
  logic r_div;
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
`endif
  assign w_accept = (r_state == MDU_IDLE) && i_con_Start && w_op_ok;
  assign w_busy   = (r_state != MDU_IDLE);

  assign w_sa    = w_signed & i_data_A[WIDTH-1];
  assign w_sb    = w_signed & i_data_B[WIDTH-1];
  assign w_abs_a = w_sa ? ({WIDTH{1'b0}} - i_data_A) : i_data_A;
  assign w_abs_b = w_sb ? ({WIDTH{1'b0}} - i_data_B) : i_data_B;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mag_b (r_mag_b),
`ifdef ARC_MDU_DIV_EN
    .i_div   (r_div),
`endif
    .o_acc   (w_acc_next)
  );

  // Sign fix-up applied in the FIX cycle, registered into HI/LO on its closing edge.
  assign w_prod = (r_sa ^ r_sb) ? ({(2*WIDTH){1'b0}} - r_acc[2*WIDTH-1:0])
                                : r_acc[2*WIDTH-1:0];
`ifdef ARC_MDU_DIV_EN
  assign w_res_lo = r_div ? ((r_sa ^ r_sb) ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0])
                          : w_prod[WIDTH-1:0];
  assign w_res_hi = r_div ? (r_sa ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH])
                          : w_prod[2*WIDTH-1:WIDTH];
`else
  assign w_res_lo = w_prod[WIDTH-1:0];
  assign w_res_hi = w_prod[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= MDU_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_state_next = MDU_ITER;
      MDU_ITER: if (r_cnt == '0) w_state_next = MDU_FIX;
      MDU_FIX:  w_state_next = MDU_IDLE;
      default:  w_state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mag_b <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef ARC_MDU_DIV_EN
      r_div   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_acc   <= {{(WIDTH+1){1'b0}}, w_abs_a};
      r_mag_b <= {1'b0, w_abs_b};
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_cnt   <= CNT_W'(WIDTH - 1);
`ifdef ARC_MDU_DIV_EN
      r_div   <= i_con_MduOp[1];
`endif
    end else if (r_state == MDU_ITER) begin
      r_acc <= w_acc_next;
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == MDU_FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      // IDLE without an accepted start: MTHI/MTLO land on this edge.
      if (i_con_WrHi) r_hi <= i_data_A;
      if (i_con_WrLo) r_lo <= i_data_A;
    end
  end

  assign o_data_Hi   = r_hi;
  assign o_data_Lo   = r_lo;
  assign o_con_Busy  = w_busy;
  assign o_con_Stall = w_busy & (i_con_Start | i_con_RdHiLo | i_con_WrHi | i_con_WrLo);
  assign o_con_Done  = (r_state == MDU_FIX);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table through a result scoreboard plus
// hand-written sequences for reset abort, stall, MTHI/MTLO and start priority.
`timescale 1ns/1ps
module tb_mdu_ctrl;
  import arc_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, rdhilo = 1'b0, wrhi = 1'b0, wrlo = 1'b0;
  logic [1:0]   mduop = 2'd0;
  logic [W-1:0] da = '0, db = '0;
  logic [W-1:0] hi, lo;
  logic         busy, stall, done;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [W-1:0] a, b, ehi, elo;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_con_Start  (start),
    .i_con_MduOp  (mduop),
    .i_data_A     (da),
    .i_data_B     (db),
    .i_con_RdHiLo (rdhilo),
    .i_con_WrHi   (wrhi),
    .i_con_WrLo   (wrlo),
    .o_data_Hi    (hi),
    .o_data_Lo    (lo),
    .o_con_Busy   (busy),
    .o_con_Stall  (stall),
    .o_con_Done   (done)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at the negedge of cycle cyc_in; waits for Done, then checks HI/LO one cycle later.
  task automatic finish_op(input string name, input int cyc_in);
    int cyc;
    int busy_low;
    logic [2*W-1:0] e;
    cyc = cyc_in;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cyc++;
    end
    chk({name, " done_cycle"}, W'(cyc), W'(33));
    chk({name, " busy_low_cycles"}, W'(busy_low), W'(0));
    @(negedge clk);
    e = sb_q.pop_front();
    chk({name, " hi"}, hi, e[2*W-1:W]);
    chk({name, " lo"}, lo, e[W-1:0]);
    chk({name, " busy_after"}, W'(busy), W'(0));
    $display("op %-12s hi=%h lo=%h (exp %h %h)", name, hi, lo, e[2*W-1:W], e[W-1:0]);
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    @(negedge clk);
    start = 1'b1; mduop = op; da = a; db = b;
    sb_q.push_back({ehi, elo});
    @(negedge clk);
    start = 1'b0;
    finish_op(name, 1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int stall_n;

    vecs.push_back('{"multu_3x5",   2'd1, 32'd3,        32'd5,        32'h0000_0000, 32'd15});
    vecs.push_back('{"mult_m7x6",   2'd0, 32'hFFFF_FFF9, 32'd6,       32'hFFFF_FFFF, 32'hFFFF_FFD6});
    vecs.push_back('{"multu_max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_min2",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"mult_minx1",  2'd0, 32'h8000_0000, 32'd1,       32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"mult_neg1",   2'd0, 32'd12345,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7});
    vecs.push_back('{"multu_2p16",  2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
`ifdef ARC_MDU_DIV_EN
    vecs.push_back('{"div_m7d2",    2'd2, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_100d0",  2'd3, 32'd100,      32'd0,        32'd100,       32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"divu_100d7",  2'd3, 32'd100,      32'd7,        32'd2,         32'd14});
    vecs.push_back('{"div_7dm2",    2'd2, 32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"div_m5d0",    2'd2, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 32'h0000_0001});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst hi", hi, '0);
    chk("rst lo", lo, '0);
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst stall", W'(stall), W'(0));

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // Reset mid-ITER aborts the operation without writing HI/LO.
    @(negedge clk);
    start = 1'b1; mduop = 2'd1; da = 32'd7; db = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort hi", hi, '0);
    chk("abort lo", lo, '0);
    chk("abort busy", W'(busy), W'(0));
    chk("abort done", W'(done), W'(0));
    $display("op %-12s hi=%h lo=%h busy=%0b", "reset_abort", hi, lo, busy);
    rst = 1'b0;
    run_op("multu_3x5_b", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15);

    // Start held every cycle while busy, plus MFHI/MFLO in cycle 5.
    @(negedge clk);
    start = 1'b1; mduop = 2'd1; da = 32'd6; db = 32'd7;
    sb_q.push_back({32'd0, 32'd42});
    @(negedge clk);
    cyc = 1; stall_n = 0;
    da = 32'd1000; db = 32'd3;
    while (cyc < 40) begin
      rdhilo = (cyc == 5);
      #1;
      if (stall) stall_n++;
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    chk("stall done_cycle", W'(cyc), W'(33));
    chk("stall cycles", W'(stall_n), W'(33));
    start = 1'b0; rdhilo = 1'b1;
    @(negedge clk);
    begin
      logic [2*W-1:0] e;
      e = sb_q.pop_front();
      chk("mfhi after op", hi, e[2*W-1:W]);
      chk("mflo after op", lo, e[W-1:0]);
    end
    chk("stall idle rd", W'(stall), W'(0));
    rdhilo = 1'b0;
    @(negedge clk);
    chk("held start ignored", W'(busy), W'(0));
    $display("op %-12s hi=%h lo=%h stall_cycles=%0d", "start_spam", hi, lo, stall_n);

    // MTLO / MTHI in IDLE, then MTHI during ITER is ignored and stalled.
    @(negedge clk);
    wrlo = 1'b1; da = 32'hDEAD_BEEF;
    @(negedge clk);
    wrlo = 1'b0;
    chk("mtlo lo", lo, 32'hDEAD_BEEF);
    wrhi = 1'b1; da = 32'h1234_5678;
    @(negedge clk);
    wrhi = 1'b0;
    chk("mthi hi", hi, 32'h1234_5678);
    $display("op %-12s hi=%h lo=%h", "mthi_mtlo", hi, lo);
    start = 1'b1; mduop = 2'd1; da = 32'd2; db = 32'd3;
    sb_q.push_back({32'd0, 32'd6});
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    wrhi = 1'b1; da = 32'hAAAA_5555;
    #1;
    chk("mthi iter stall", W'(stall), W'(1));
    @(negedge clk);
    wrhi = 1'b0;
    chk("mthi iter hi", hi, 32'h1234_5678);
    finish_op("multu_2x3", 6);

    // Same-cycle Start + MTLO in IDLE: the start wins.
    @(negedge clk);
    start = 1'b1; wrlo = 1'b1; mduop = 2'd1; da = 32'd2; db = 32'd2;
    sb_q.push_back({32'd0, 32'd4});
    @(negedge clk);
    start = 1'b0; wrlo = 1'b0;
    chk("start+mtlo lo", lo, 32'd6);
    finish_op("multu_2x2", 1);

`ifndef ARC_MDU_DIV_EN
    // Divide ops are not built: the start is ignored entirely.
    @(negedge clk);
    start = 1'b1; mduop = 2'd2; da = 32'd100; db = 32'd7;
    @(negedge clk);
    start = 1'b0;
    stall_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy || done) stall_n++;
      @(negedge clk);
    end
    chk("nodiv busy/done", W'(stall_n), W'(0));
    chk("nodiv hi", hi, 32'd0);
    chk("nodiv lo", lo, 32'd4);
    $display("op %-12s hi=%h lo=%h", "div_ignored", hi, lo);
    run_op("mult_m7x6_b", 2'd0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
`endif

    chk("scoreboard empty", W'(sb_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
